// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational one-hot picker, round-robin from ptr or lowest-index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [SEL_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] gidx,
    output logic             any
);

    localparam logic [SEL_W:0] c_n = (SEL_W + 1)'(N);

    logic [SEL_W:0]   w_idx;
    logic [SEL_W-1:0] w_start;

    // Unrolled scan from the start index; one extra index bit lets the wrap
    // work for channel counts that are not a power of two.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        any     = 1'b0;
        w_idx   = '0;
        w_start = rr_mode ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, w_start} + (SEL_W + 1)'(k);
            if (w_idx >= c_n) begin
                w_idx = w_idx - c_n;
            end
            if (!any && elig[w_idx[SEL_W-1:0]]) begin
                any                       = 1'b1;
                grant[w_idx[SEL_W-1:0]]   = 1'b1;
                gidx                      = w_idx[SEL_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : N-channel valid/ready arbiter feeding one registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_mux #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int RR    = 1,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    input  logic             out_ready
);

    localparam logic [SEL_W:0]   c_n    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(N - 1);

    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_ptr;

    logic [N-1:0]     w_force_mask;
    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic             w_any;
    logic             w_load;
    logic [W-1:0]     w_win_data;

    // Out-of-range forced index leaves the mask empty, so nothing is granted.
    always_comb begin
        w_force_mask = '0;
        if ({1'b0, force_sel} < c_n) begin
            w_force_mask[force_sel] = 1'b1;
        end
    end

    assign w_elig = force_en ? (in_valid & w_force_mask) : in_valid;
    assign w_load = ~r_out_valid | out_ready;

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .elig    (w_elig),
        .ptr     (r_ptr),
        .rr_mode (RR != 0),
        .grant   (w_grant),
        .gidx    (w_gidx),
        .any     (w_any)
    );

    // No handshake is offered while in reset: the word would be dropped.
    assign in_ready = (w_load && rst_n) ? w_grant : '0;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_win_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_win_data;
                r_out_chan <= w_gidx;
                if (RR != 0) begin
                    r_ptr <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// Module   : tb_rr_arb_mux
// Purpose  : Scoreboard bench for a round-robin and a fixed-priority instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        force_en;
    logic [1:0]  force_sel;
    logic        out_ready;

    logic [3:0]  rdy_rr, rdy_fp;
    logic        ov_rr, ov_fp;
    logic [7:0]  od_rr, od_fp;
    logic [1:0]  oc_rr, oc_fp;

    int total = 0;
    int bad   = 0;

    // Reference state: output-register occupancy, rotation pointer, pending words.
    bit          mv[2];
    int          mptr[2];
    logic [9:0]  q_rr[$];
    logic [9:0]  q_fp[$];
    logic [7:0]  chdata[4];
    logic [9:0]  mon_ent;

    rr_arb_mux #(.N(4), .W(8), .RR(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy_rr),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (ov_rr),
        .out_data  (od_rr),
        .out_chan  (oc_rr),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.N(4), .W(8), .RR(0)) u_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy_fp),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (ov_fp),
        .out_data  (od_fp),
        .out_chan  (oc_fp),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational/handshake view, advance model.
    task automatic step(input bit rn, input logic [3:0] v, input bit fe,
                        input logic [1:0] fs, input bit ordy);
        int         win;
        int         c;
        bit         load;
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        logic [3:0] act_rdy;
        logic       act_ov;
        rst_n     = rn;
        in_valid  = v;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = chdata[i];
        #1;
        for (int m = 0; m < 2; m++) begin
            load = !mv[m] || ordy;
            for (int i = 0; i < 4; i++) elig[i] = v[i] && (!fe || fs == 2'(i));
            win = -1;
            for (int k = 0; k < 4; k++) begin
                c = (m == 0) ? (mptr[m] + k) % 4 : k;
                if (win < 0 && elig[c]) win = c;
            end
            exp_rdy = (rn && load && win >= 0) ? 4'(1 << win) : 4'b0;
            act_rdy = (m == 0) ? rdy_rr : rdy_fp;
            act_ov  = (m == 0) ? ov_rr : ov_fp;
            chk($sformatf("%s in_ready", m ? "fp" : "rr"), int'(act_rdy), int'(exp_rdy));
            chk($sformatf("%s out_valid", m ? "fp" : "rr"), int'(act_ov), int'(mv[m]));
            if (!rn) begin
                mv[m]   = 0;
                mptr[m] = 0;
                if (m == 0) q_rr.delete(); else q_fp.delete();
            end else if (load) begin
                if (win >= 0) begin
                    if (m == 0) q_rr.push_back({2'(win), chdata[win]});
                    else        q_fp.push_back({2'(win), chdata[win]});
                    mv[m] = 1;
                    if (m == 0) mptr[m] = (win + 1) % 4;
                end else begin
                    mv[m] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every word the consumer accepts must be the oldest expected one.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_ready) begin
            if (ov_rr) begin
                chk("rr word expected", int'(q_rr.size() > 0), 1);
                if (q_rr.size() > 0) begin
                    mon_ent = q_rr.pop_front();
                    chk("rr out_chan", int'(oc_rr), int'(mon_ent[9:8]));
                    chk("rr out_data", int'(od_rr), int'(mon_ent[7:0]));
                end
            end
            if (ov_fp) begin
                chk("fp word expected", int'(q_fp.size() > 0), 1);
                if (q_fp.size() > 0) begin
                    mon_ent = q_fp.pop_front();
                    chk("fp out_chan", int'(oc_fp), int'(mon_ent[9:8]));
                    chk("fp out_data", int'(od_fp), int'(mon_ent[7:0]));
                end
            end
        end
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv[i]   = 0;
            mptr[i] = 0;
        end
        for (int i = 0; i < 4; i++) chdata[i] = 8'hA0 + 8'(i);
        @(negedge clk);

        // Reset held with all channels requesting
        repeat (2) step(0, 4'hF, 0, 2'd0, 1);
        chk("reset out_data", int'(od_rr), 0);
        chk("reset out_chan", int'(oc_rr), 0);

        // Round-robin start, backpressure holding A1, then resume at ch2
        repeat (2) step(1, 4'hF, 0, 2'd0, 1);
        repeat (3) step(1, 4'hF, 0, 2'd0, 0);
        chk("stall hold data", int'(od_rr), 8'hA1);
        repeat (6) step(1, 4'hF, 0, 2'd0, 1);

        // Fixed-priority pattern, then ch1 drops out
        repeat (4) step(1, 4'b1010, 0, 2'd0, 1);
        repeat (2) step(1, 4'b1000, 0, 2'd0, 1);

        // Forced select on ch2, then forced channel not valid
        repeat (3) step(1, 4'hF, 1, 2'd2, 1);
        repeat (2) step(1, 4'b1011, 1, 2'd2, 1);

        // Mid-stream reset with pointer at 3 and a word pending
        step(1, 4'b0100, 0, 2'd0, 1);
        step(0, 4'hF, 0, 2'd0, 1);
        repeat (3) step(1, 4'hF, 0, 2'd0, 1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) chdata[i] = 8'($urandom);
            step($urandom_range(0, 49) != 0, 4'($urandom), $urandom_range(0, 4) == 0,
                 2'($urandom), $urandom_range(0, 9) < 7);
        end

        // Drain: every expected word must have been presented
        repeat (3) step(1, 4'h0, 0, 2'd0, 1);
        chk("rr queue drained", q_rr.size(), 0);
        chk("fp queue drained", q_fp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit successor to the 2:1 select mux.
- Arbitrates among N valid/ready input channels and registers the winning channel's data into one output stage.
- Arbitration is round-robin or fixed-priority, with an optional forced-select override that reproduces plain mux behaviour.
- Sits between multiple producers and a single shared consumer in the datapath.

Parameters:
- N, 4: number of input channels; N >= 2.
- W, 8: data width per channel.
- RR, 1: 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest).
- SEL_W, $clog2(N): select/channel-index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  N  per-channel valid
- in_data  in  N*W  flattened channel data; channel i occupies bits [i*W +: W]
- in_ready  out  N  per-channel ready, one-hot or zero
- force_en  in  1  when 1, only channel force_sel is eligible
- force_sel  in  SEL_W  forced channel index
- out_valid  out  1  output register holds valid data
- out_data  out  W  registered data
- out_chan  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data

Behaviour:
- **Reset.** Synchronous active-low: rst_n sampled low at a rising clk edge sets out_valid=0, out_data=0, out_chan=0 and ptr=0. Reset wins over every simultaneous event, including mid-transfer; any in-flight output word is dropped.
- **Load.** load = !out_valid | out_ready, combinational. This gives full throughput: one transfer per cycle under continuous out_ready.
- **Eligibility.** elig = in_valid when force_en=0. When force_en=1, elig = in_valid & onehot(force_sel). If force_sel >= N, elig = 0 and nothing is granted.
- **Grant.** One-hot over elig.
  - RR=1: search starts at ptr and wraps modulo N; the first eligible index wins.
  - RR=0: the lowest eligible index wins; ptr is unused.
- **in_ready.** in_ready = grant when load=1, else 0. in_ready depends combinationally on in_valid, force_en, force_sel and out_ready. Producers must not make in_valid depend on in_ready.
- **Transfer.** Occurs when load=1 and grant != 0. On the next edge: out_valid=1, out_data=in_data[g], out_chan=g. If RR=1, ptr = (g+1) mod N, wrapping from N-1 to 0.
- **Load with no grant.** out_valid=0; out_data and out_chan hold their previous values.
- **Stall.** When out_valid=1 and out_ready=0: out_data, out_chan and out_valid are held stable, in_ready=0, and ptr is unchanged.
- **Latency.** One cycle from the in_valid&in_ready handshake to out_valid.
- **Force mode.** ptr advances normally on forced transfers when RR=1.
- **No combinational paths** from in_* to out_valid, out_data or out_chan.

Decomposition:
- No package is needed. SEL_W is a localparam-derived constant computed in the top module.
- One natural sub-module: rr_priority_pick (combinational). Inputs: elig[N], ptr[SEL_W], rr_mode. Outputs: grant[N] one-hot, gidx[SEL_W], any. Implement it with a double-width rotate or an unrolled loop.
- The top module contains the output register, ptr register, load logic and force masking.

Test Plan (N=4, W=8):
1. **Reset.** Hold rst_n=0 for 2 edges with in_valid=4'hF → out_valid=0, out_data=8'h00, out_chan=0, in_ready=0 after the edge. Release → first grant goes to ch0.
2. **Round-robin fairness.** RR=1, in_valid=4'hF constant, data ch i = 8'hA0+i, out_ready=1 → out_chan sequence 0,1,2,3,0,1 on consecutive cycles with out_data A0,A1,A2,A3,A0. Each in_ready is asserted exactly once per 4 cycles.
3. **Backpressure.** With out_valid=1 (out_data=A1), drop out_ready for 3 cycles → out_data stays A1, in_ready=0, ptr is not advanced. Raise out_ready → next grant is ch2.
4. **Fixed priority.** RR=0, in_valid=4'b1010 → ch1 is granted every cycle and ch3 starves. Clear ch1 valid → ch3 is granted.
5. **Forced select.** force_en=1, force_sel=2, in_valid=4'hF → only ch2 is granted (out_data=A2), in_ready=4'b0100. With force_sel=2 and in_valid[2]=0 → out_valid falls to 0 after the edge.
6. **Mid-stream reset.** Drive rst_n=0 on an edge where out_valid=1 and a transfer is pending → out_valid=0, ptr=0. After release, ch0 is granted first despite the previous ptr=3.
